// File: rtl/seg_blink_scan_if.sv
// Display bus between the panel logic and the seven-segment scan driver.
// Master drives the digit data, decimal points, blink mask and blink phase. Slave returns the segment, select and phase outputs.
interface seg_blink_scan_if;
    logic        invert;
    logic [15:0] digit_data;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        phase;

    modport master (
        output invert, digit_data, dp_in, blink_mask,
        input  seg, sel, phase
    );

    modport slave (
        input  invert, digit_data, dp_in, blink_mask,
        output seg, sel, phase
    );
endinterface

// File: rtl/seg_blink_scan.sv
// Four-digit seven-segment scan driver with per-frame snapshot, anti-ghost blanking and SEG_BLINK_EN digit blinking.
// seg/sel are registered one cycle after cnt/idx. Free-running scan with no backpressure; inputs apply at the next frame snapshot.
module seg_blink_scan #(
    parameter int unsigned SCAN_DIV     = 12000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    seg_blink_scan_if.slave bus
);

    localparam logic [31:0] LAST  = 32'(SCAN_DIV - 1);
    localparam logic [31:0] BLANK = 32'(BLANK_CYCLES);

    logic [31:0] cnt;
    logic [1:0]  idx;
    logic        valid;
    logic [15:0] data_sh;
    logic [3:0]  dp_sh;
    logic [7:0]  seg_q;
    logic [3:0]  sel_q;

    logic        wrap;
    logic        snap;
    logic        blank;
    logic        blink_on;
    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic [3:0]  sel_digit;

    assign wrap      = (cnt == LAST);
    // The first edge after reset loads the shadows so the panel never shows stale zeros for a whole frame.
    assign snap      = !valid || (wrap && (idx == 2'd3));
    assign blank     = (cnt < BLANK) || !valid;
    assign sel_digit = ~(4'b0001 << idx);
    assign nib       = data_sh[{idx, 2'b00} +: 4];

    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

`ifdef SEG_BLINK_EN
    logic       inv_s1;
    logic       inv_s;
    logic       phase_q;
    logic [3:0] mask_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_s1  <= 1'b0;
            inv_s   <= 1'b0;
            phase_q <= 1'b0;
            mask_sh <= 4'h0;
        end else begin
            inv_s1 <= bus.invert;
            inv_s  <= inv_s1;
            if (snap) begin
                phase_q <= inv_s;
                mask_sh <= bus.blink_mask;
            end
        end
    end

    assign blink_on  = mask_sh[idx] & phase_q;
    assign bus.phase = phase_q;
`else
    logic unused_blink;

    assign unused_blink = ^{bus.invert, bus.blink_mask};
    assign blink_on     = 1'b0;
    assign bus.phase    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 32'd0;
            idx     <= 2'd0;
            valid   <= 1'b0;
            data_sh <= 16'h0000;
            dp_sh   <= 4'h0;
            seg_q   <= 8'hFF;
            sel_q   <= 4'b1111;
        end else begin
            cnt <= wrap ? 32'd0 : cnt + 32'd1;
            if (wrap)
                idx <= idx + 2'd1;
            if (snap) begin
                valid   <= 1'b1;
                data_sh <= bus.digit_data;
                dp_sh   <= bus.dp_in;
            end
            if (blank) begin
                sel_q <= 4'b1111;
                seg_q <= 8'hFF;
            end else if (blink_on) begin
                sel_q <= sel_digit;
                seg_q <= 8'hFF;
            end else begin
                sel_q <= sel_digit;
                seg_q <= {~dp_sh[idx], glyph};
            end
        end
    end

    assign bus.seg = seg_q;
    assign bus.sel = sel_q;

endmodule

// File: tb/tb_seg_blink_scan.sv
// Scoreboard bench for seg_blink_scan at SCAN_DIV=8, BLANK_CYCLES=2; blink expectations follow SEG_BLINK_EN.
module tb_seg_blink_scan;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       ph;
        int         tag;
    } exp_t;

`ifdef SEG_BLINK_EN
    localparam logic       PH_C  = 1'b1;
    localparam logic [7:0] SEG2C = 8'hFF;
`else
    localparam logic       PH_C  = 1'b0;
    localparam logic [7:0] SEG2C = 8'hA4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t q[$];
    exp_t e;
    int   n_total = 0;
    int   n_pass  = 0;

    seg_blink_scan_if bus ();

    seg_blink_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One expectation per output cycle: 2 blanked then 6 lit per slot; the last entry carries the next frame's phase.
    task automatic push_frame(input int frame, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input logic ph, input logic ph_last, input int n);
        logic [7:0] segs [4];
        exp_t x;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int j = 0; j < n; j++) begin
            x.tag = frame * 100 + j;
            x.ph  = (j == 31) ? ph_last : ph;
            if ((j % 8) < 2) begin
                x.sel = 4'b1111;
                x.seg = 8'hFF;
            end else begin
                x.sel = 4'b1111;
                x.sel[j / 8] = 1'b0;
                x.seg = segs[j / 8];
            end
            q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if (bus.sel === e.sel && bus.seg === e.seg && bus.phase === e.ph)
                n_pass++;
            else
                $display("FAIL slot %0d: got sel=%b seg=%h phase=%b, want sel=%b seg=%h phase=%b",
                         e.tag, bus.sel, bus.seg, bus.phase, e.sel, e.seg, e.ph);
        end
    end

    initial begin
        exp_t r;
        bus.digit_data = 16'h1234;
        bus.dp_in      = 4'b0000;
        bus.blink_mask = 4'b0000;
        bus.invert     = 1'b0;
        r.sel = 4'b1111; r.seg = 8'hFF; r.ph = 1'b0; r.tag = 0;
        q.push_back(r);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        @(posedge clk); #1;
        push_frame(1, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 1'b0, 32);

        repeat (11) @(posedge clk); #1;
        bus.digit_data = 16'hABCD;
        push_frame(2, 8'hA1, 8'hC6, 8'h83, 8'h88, 1'b0, PH_C, 32);

        repeat (28) @(posedge clk); #1;
        bus.digit_data = 16'h1234;
        bus.dp_in      = 4'b0001;
        bus.blink_mask = 4'b0100;
        bus.invert     = 1'b1;
        push_frame(3, 8'h19, 8'hB0, SEG2C, 8'hF9, PH_C, 1'b0, 32);

        repeat (30) @(posedge clk); #1;
        bus.invert = 1'b0;

        // Changed one cycle before the snapshot edge, so this frame must capture it.
        repeat (25) @(posedge clk); #1;
        bus.digit_data = 16'h0000;
        push_frame(4, 8'h40, 8'hC0, 8'hC0, 8'hC0, 1'b0, 1'b0, 21);

        repeat (22) @(posedge clk); #1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (bus.sel === 4'b1111 && bus.seg === 8'hFF && bus.phase === 1'b0)
            n_pass++;
        else
            $display("FAIL rst_async: got sel=%b seg=%h phase=%b, want sel=1111 seg=ff phase=0",
                     bus.sel, bus.seg, bus.phase);

        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        push_frame(5, 8'h40, 8'hC0, 8'hC0, 8'hC0, 1'b0, 1'b0, 32);

        for (int i = 0; i < 100 && q.size() != 0; i++)
            @(negedge clk);
        #1;
        n_total++;
        if (q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: %0d expectations left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
